// File: rtl/mc_ctrl_pkg.sv
// Shared opcode, ALU-code, state and decoded-control definitions for the
// multi-cycle accumulator/register-file CPU control unit.
package mc_ctrl_pkg;

    localparam logic [2:0] OP_ACM  = 3'b000;
    localparam logic [2:0] OP_ACMI = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_NAND = 3'b011;
    localparam logic [2:0] OP_BNZ  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SW   = 3'b110;
    localparam logic [2:0] OP_LW   = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_NAND = 2'b01;
    localparam logic [1:0] ALU_NZ   = 2'b10;
    localparam logic [1:0] ALU_LT   = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Which write strobe an EXEC-class instruction fires.
    typedef enum logic [1:0] {
        WC_NONE = 2'd0,
        WC_ACC  = 2'd1,
        WC_REG  = 2'd2,
        WC_BR   = 2'd3
    } wr_class_t;

    typedef struct packed {
        logic [1:0] cntr_alu;
        logic       selAluIn;
        logic       lw;
        logic       selAccIn;
        logic       selMemIn;
        logic       is_mem;
        logic       is_store;
        wr_class_t  wr_class;
    } dec_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode decoder: every field is defined for all eight opcodes,
// with fields an opcode does not use held at zero.
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [2:0] i_opcode,
    output dec_t       o_dec
);

    always_comb begin
        o_dec = '0;
        case (i_opcode)
            OP_ACM: begin
                o_dec.wr_class = WC_ACC;
            end
            OP_ACMI: begin
                o_dec.selAccIn = 1'b1;
                o_dec.wr_class = WC_ACC;
            end
            OP_ADD: begin
                o_dec.cntr_alu = ALU_ADD;
                o_dec.selAluIn = 1'b1;
                o_dec.wr_class = WC_REG;
            end
            OP_NAND: begin
                o_dec.cntr_alu = ALU_NAND;
                o_dec.selAluIn = 1'b1;
                o_dec.wr_class = WC_REG;
            end
            OP_BNZ: begin
                o_dec.cntr_alu = ALU_NZ;
                o_dec.wr_class = WC_BR;
            end
            OP_SLT: begin
                o_dec.cntr_alu = ALU_LT;
                o_dec.selAluIn = 1'b1;
                o_dec.wr_class = WC_REG;
            end
            OP_SW: begin
                o_dec.selMemIn = 1'b1;
                o_dec.is_mem   = 1'b1;
                o_dec.is_store = 1'b1;
            end
            OP_LW: begin
                o_dec.lw       = 1'b1;
                o_dec.selMemIn = 1'b1;
                o_dec.is_mem   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle control unit: IDLE/FETCH/DECODE/EXEC/MEM/WB sequencing with a
// valid/ready fetch handshake and a bounded wait on data-memory ready.
module multicycle_controlunit
    import mc_ctrl_pkg::*;
#(
    parameter int INST_W      = 8,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = $clog2(MEM_TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_valid,
    input  logic [INST_W-1:0] instruction,
    output logic              inst_ready,
    input  logic              mem_ready,
    output logic [INST_W-4:0] operand,
    output logic [1:0]        cntr_alu,
    output logic              selAluIn,
    output logic              lw,
    output logic              selAccIn,
    output logic              selMemIn,
    output logic              regWE,
    output logic              memWE,
    output logic              accWE,
    output logic              brnch,
    output logic              pc_en,
    output logic              err,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [INST_W-1:0] r_ir;
    logic [CNT_W-1:0]  r_cnt;
    dec_t              r_dec;
    dec_t              w_dec;
    logic              w_cnt_last;

    mc_decode u_decode (
        .i_opcode (r_ir[INST_W-1 -: 3]),
        .o_dec    (w_dec)
    );

    assign w_cnt_last = (r_cnt == LP_CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ir    <= '0;
            r_cnt   <= '0;
            r_dec   <= '0;
        end else begin
            case (r_state)
                S_IDLE: r_state <= S_FETCH;
                S_FETCH: begin
                    if (inst_valid) begin
                        r_ir    <= instruction;
                        r_state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_dec   <= w_dec;
                    r_cnt   <= '0;
                    r_state <= w_dec.is_mem ? S_MEM : S_EXEC;
                end
                S_EXEC: r_state <= S_FETCH;
                S_MEM: begin
                    // Ready on the last allowed cycle still counts as success.
                    if (mem_ready) begin
                        r_state <= (r_dec.is_mem && !r_dec.is_store) ? S_WB : S_FETCH;
                    end else if (w_cnt_last) begin
                        r_state <= S_FETCH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WB: r_state <= S_FETCH;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        inst_ready = (r_state == S_FETCH);
        busy       = !(r_state == S_IDLE || r_state == S_FETCH);
        regWE      = 1'b0;
        memWE      = 1'b0;
        accWE      = 1'b0;
        brnch      = 1'b0;
        pc_en      = 1'b0;
        err        = 1'b0;
        case (r_state)
            S_EXEC: begin
                pc_en = 1'b1;
                accWE = (r_dec.wr_class == WC_ACC);
                regWE = (r_dec.wr_class == WC_REG);
                brnch = (r_dec.wr_class == WC_BR);
            end
            S_MEM: begin
                // A store abandoned by timeout does not write on the abort cycle.
                memWE = r_dec.is_store && (mem_ready || !w_cnt_last);
                pc_en = r_dec.is_store && mem_ready;
                err   = !mem_ready && w_cnt_last;
            end
            S_WB: begin
                regWE = 1'b1;
                pc_en = 1'b1;
            end
            default: ;
        endcase
    end

    assign operand  = r_ir[INST_W-4:0];
    assign cntr_alu = r_dec.cntr_alu;
    assign selAluIn = r_dec.selAluIn;
    assign lw       = r_dec.lw;
    assign selAccIn = r_dec.selAccIn;
    assign selMemIn = r_dec.selMemIn;

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit: a per-instruction cycle model
// predicts every output each cycle, plus literal spot checks on key cycles.
module tb_multicycle_controlunit;

    localparam int TO = 15;

    typedef struct packed {
        logic       inst_ready;
        logic [4:0] operand;
        logic [1:0] cntr_alu;
        logic       selAluIn;
        logic       lw;
        logic       selAccIn;
        logic       selMemIn;
        logic       regWE;
        logic       memWE;
        logic       accWE;
        logic       brnch;
        logic       pc_en;
        logic       err;
        logic       busy;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       inst_valid;
    logic [7:0] instruction;
    logic       inst_ready;
    logic       mem_ready;
    logic [4:0] operand;
    logic [1:0] cntr_alu;
    logic       selAluIn, lw, selAccIn, selMemIn;
    logic       regWE, memWE, accWE, brnch, pc_en, err, busy;

    multicycle_controlunit #(
        .INST_W      (8),
        .MEM_TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_valid  (inst_valid),
        .instruction (instruction),
        .inst_ready  (inst_ready),
        .mem_ready   (mem_ready),
        .operand     (operand),
        .cntr_alu    (cntr_alu),
        .selAluIn    (selAluIn),
        .lw          (lw),
        .selAccIn    (selAccIn),
        .selMemIn    (selMemIn),
        .regWE       (regWE),
        .memWE       (memWE),
        .accWE       (accWE),
        .brnch       (brnch),
        .pc_en       (pc_en),
        .err         (err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    vec_t  exp_q[$];
    string name_q[$];
    vec_t  act;

    always_comb act = {inst_ready, operand, cntr_alu, selAluIn, lw, selAccIn,
                       selMemIn, regWE, memWE, accWE, brnch, pc_en, err, busy};

    // Held fields of the model: operand of the last accepted instruction and
    // the controls of the last decoded one.
    logic [4:0] m_operand;
    logic [1:0] m_alu;
    logic       m_sai, m_lw, m_sacc, m_smem;

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            vec_t  e;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            checks++;
            if (act !== e)
                begin
                    errors++;
                    $display("FAIL %s @%0t: got %05h expected %05h", n, $time, act, e);
                end
        end
    end

    int n_memwe = 0, n_pcen = 0, n_regwe = 0, n_err = 0;
    int s_memwe, s_pcen, s_regwe, s_err;

    always @(negedge clk) begin
        if (memWE) n_memwe++;
        if (pc_en) n_pcen++;
        if (regWE) n_regwe++;
        if (err)   n_err++;
    end

    task automatic snap();
        s_memwe = n_memwe;
        s_pcen  = n_pcen;
        s_regwe = n_regwe;
        s_err   = n_err;
    endtask

    task automatic lit(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, a, e);
        end
    endtask

    function automatic logic [7:0] rnd8();
        return 8'($urandom);
    endfunction

    function automatic logic rnd1();
        return 1'($urandom);
    endfunction

    task automatic model_reset();
        m_operand = '0;
        m_alu     = '0;
        m_sai     = 1'b0;
        m_lw      = 1'b0;
        m_sacc    = 1'b0;
        m_smem    = 1'b0;
    endtask

    // ALU ops only for ADD/NAND/BNZ/SLT; RF input only for ALU-register ops.
    task automatic latch_rules(input logic [2:0] op);
        m_alu  = (op == 3'd3) ? 2'b01 :
                 (op == 3'd4) ? 2'b10 :
                 (op == 3'd5) ? 2'b11 : 2'b00;
        m_sai  = (op == 3'd2 || op == 3'd3 || op == 3'd5);
        m_lw   = (op == 3'd7);
        m_sacc = (op == 3'd1);
        m_smem = (op >= 3'd6);
    endtask

    function automatic vec_t base(input logic busy_f);
        vec_t e;
        e          = '0;
        e.operand  = m_operand;
        e.cntr_alu = m_alu;
        e.selAluIn = m_sai;
        e.lw       = m_lw;
        e.selAccIn = m_sacc;
        e.selMemIn = m_smem;
        e.busy     = busy_f;
        return e;
    endfunction

    task automatic cyc(input logic r, input logic v, input logic [7:0] ins,
                       input logic mr, input vec_t e, input string nm);
        @(posedge clk);
        #1;
        rst         = r;
        inst_valid  = v;
        instruction = ins;
        mem_ready   = mr;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // ready_at: 1-based MEM cycle on which mem_ready is raised (0 = never).
    task automatic run_instr(input logic [7:0] ins, input int gap, input int ready_at);
        logic [2:0] op;
        vec_t       e;
        logic       rdy;
        logic       done;
        op = ins[7:5];
        for (int g = 0; g < gap; g++) begin
            e = base(1'b0);
            e.inst_ready = 1'b1;
            cyc(1'b0, 1'b0, rnd8(), rnd1(), e, "fetch_wait");
        end
        e = base(1'b0);
        e.inst_ready = 1'b1;
        cyc(1'b0, 1'b1, ins, rnd1(), e, "fetch");
        m_operand = ins[4:0];
        e = base(1'b1);
        cyc(1'b0, 1'b0, rnd8(), rnd1(), e, "decode");
        latch_rules(op);
        if (op < 3'd6) begin
            e = base(1'b1);
            e.pc_en = 1'b1;
            e.accWE = (op <= 3'd1);
            e.regWE = (op == 3'd2 || op == 3'd3 || op == 3'd5);
            e.brnch = (op == 3'd4);
            cyc(1'b0, 1'b0, rnd8(), rnd1(), e, "exec");
        end else begin
            done = 1'b0;
            for (int c = 1; c <= TO && !done; c++) begin
                rdy = (c == ready_at);
                e = base(1'b1);
                e.memWE = (op == 3'd6) && (rdy || c < TO);
                e.pc_en = (op == 3'd6) && rdy;
                e.err   = !rdy && (c == TO);
                cyc(1'b0, 1'b0, rnd8(), rdy, e, "mem");
                done = rdy || (c == TO);
            end
            if (op == 3'd7 && ready_at >= 1 && ready_at <= TO) begin
                e = base(1'b1);
                e.regWE = 1'b1;
                e.pc_en = 1'b1;
                cyc(1'b0, 1'b0, rnd8(), rnd1(), e, "writeback");
            end
        end
    endtask

    task automatic idle_fetch(input string nm);
        vec_t e;
        e = base(1'b0);
        e.inst_ready = 1'b1;
        cyc(1'b0, 1'b0, rnd8(), rnd1(), e, nm);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1; inst_valid = 1'b0; instruction = '0; mem_ready = 1'b0;
        model_reset();
        repeat (2) cyc(1'b1, 1'b0, rnd8(), rnd1(), '0, "in_reset");
        cyc(1'b0, 1'b0, rnd8(), rnd1(), '0, "idle_after_reset");
        settle();
        lit("idle_inst_ready", int'(inst_ready), 0);
        snap();

        // ADD 010_00011: regWE/pc_en at t+2, next fetch at t+3
        run_instr(8'b010_00011, 1, 0);
        settle();
        lit("add_operand", int'(operand), 3);
        lit("add_cntr_alu", int'(cntr_alu), 0);
        lit("add_selAluIn", int'(selAluIn), 1);
        lit("add_regWE", int'(regWE), 1);
        lit("add_pc_en", int'(pc_en), 1);
        idle_fetch("fetch_after_add");
        settle();
        lit("add_then_inst_ready", int'(inst_ready), 1);
        snap();

        // BNZ then ACMI back-to-back
        run_instr(8'b100_00001, 0, 0);
        settle();
        lit("bnz_brnch", int'(brnch), 1);
        lit("bnz_pc_en", int'(pc_en), 1);
        lit("bnz_cntr_alu", int'(cntr_alu), 2);
        run_instr(8'b001_00111, 0, 0);
        settle();
        lit("acmi_accWE", int'(accWE), 1);
        lit("acmi_selAccIn", int'(selAccIn), 1);
        lit("bnz_acmi_regWE_cnt", n_regwe - s_regwe, 0);
        lit("bnz_acmi_memWE_cnt", n_memwe - s_memwe, 0);
        snap();

        // SW, mem_ready low for 3 MEM cycles
        run_instr(8'b110_00101, 0, 4);
        settle();
        lit("sw_last_pc_en", int'(pc_en), 1);
        lit("sw_memWE_cnt", n_memwe - s_memwe, 4);
        lit("sw_pc_en_cnt", n_pcen - s_pcen, 1);
        snap();

        // LW with immediate mem_ready
        run_instr(8'b111_00010, 0, 1);
        settle();
        lit("lw_wb_regWE", int'(regWE), 1);
        lit("lw_wb_lw", int'(lw), 1);
        lit("lw_wb_pc_en", int'(pc_en), 1);
        lit("lw_memWE_cnt", n_memwe - s_memwe, 0);

        run_instr(8'b000_10000, 0, 0);
        run_instr(8'b011_11111, 2, 0);
        run_instr(8'b101_01010, 0, 0);
        settle();
        snap();

        // LW timeout: never ready
        run_instr(8'b111_11100, 0, 0);
        settle();
        lit("to_err", int'(err), 1);
        lit("to_regWE", int'(regWE), 0);
        lit("to_err_cnt", n_err - s_err, 1);
        lit("to_regWE_cnt", n_regwe - s_regwe, 0);
        lit("to_pc_en_cnt", n_pcen - s_pcen, 0);
        idle_fetch("fetch_after_timeout");
        settle();
        lit("to_then_inst_ready", int'(inst_ready), 1);
        snap();

        // LW ready exactly on the last allowed cycle
        run_instr(8'b111_00001, 0, TO);
        settle();
        lit("late_lw_regWE", int'(regWE), 1);
        lit("late_lw_err_cnt", n_err - s_err, 0);
        lit("late_lw_regWE_cnt", n_regwe - s_regwe, 1);
        snap();

        run_instr(8'b110_11000, 0, 1);
        settle();
        lit("sw_fast_memWE_cnt", n_memwe - s_memwe, 1);
        lit("sw_fast_pc_en_cnt", n_pcen - s_pcen, 1);

        // Reset asserted while an LW waits in MEM
        e = base(1'b0); e.inst_ready = 1'b1;
        cyc(1'b0, 1'b1, 8'b111_01010, 1'b0, e, "rl_fetch");
        m_operand = 5'b01010;
        e = base(1'b1);
        cyc(1'b0, 1'b0, rnd8(), 1'b0, e, "rl_decode");
        latch_rules(3'd7);
        repeat (2) begin
            e = base(1'b1);
            cyc(1'b0, 1'b0, rnd8(), 1'b0, e, "rl_mem");
        end
        model_reset();
        cyc(1'b1, 1'b0, rnd8(), 1'b1, '0, "rl_reset");
        settle();
        lit("rl_busy", int'(busy), 0);
        lit("rl_regWE", int'(regWE), 0);
        lit("rl_selMemIn", int'(selMemIn), 0);
        lit("rl_operand", int'(operand), 0);
        cyc(1'b1, 1'b0, rnd8(), 1'b1, '0, "rl_reset2");
        cyc(1'b0, 1'b0, rnd8(), rnd1(), '0, "rl_idle");
        idle_fetch("rl_fetch_after");
        settle();
        lit("rl_inst_ready", int'(inst_ready), 1);

        run_instr(8'b010_00001, 0, 0);
        idle_fetch("final_fetch");
        settle();
        lit("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: stimulus did not complete by %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
